// File: rtl/dram_copy_engine.sv
// ============================================================================
// dram_copy_engine : DRAM-to-DRAM burst word copier with byte-serial echo
// Rev 1.0
// ============================================================================
`default_nettype none

module dram_copy_engine #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 13,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              err,
    output logic              AR_VALID,
    input  logic              AR_READY,
    output logic [31:0]       AR_ADDR,
    input  logic              R_VALID,
    output logic              R_READY,
    input  logic [DATA_W-1:0] R_DATA,
    input  logic [1:0]        R_RESP,
    output logic              AW_VALID,
    input  logic              AW_READY,
    output logic [31:0]       AW_ADDR,
    output logic              W_VALID,
    input  logic              W_READY,
    output logic [DATA_W-1:0] W_DATA,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [1:0]        B_RESP
);

    localparam int BYTES = DATA_W / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_WR   = 3'd3,
        S_B    = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W:0]    r_idx;
    logic [DATA_W-1:0] r_buf;
    logic              r_err;
    logic              r_aw_done;
    logic              r_w_done;
    logic [BW-1:0]     r_byte;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_wr_done;
    logic              w_last_word;
    logic              w_last_byte;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_shifted;

    // Address arithmetic wraps naturally at ADDR_W bits.
    assign w_rd_addr   = r_src + ADDR_W'(r_idx);
    assign w_wr_addr   = r_dst + ADDR_W'(r_idx);
    assign w_last_word = (r_idx == {1'b0, r_len});
    assign w_last_byte = (r_byte == BW'(BYTES - 1));
    assign w_shifted   = r_buf << {r_byte, 3'b000};
    assign w_aw_hs     = (r_state == S_WR) && !r_aw_done && AW_READY;
    assign w_w_hs      = (r_state == S_WR) && !r_w_done && W_READY;
    assign w_wr_done   = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every output is decoded from registered state only.
    always_comb begin
        w_next    = r_state;
        busy      = (r_state != S_IDLE);
        err       = r_err;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        AR_VALID  = 1'b0;
        AR_ADDR   = 32'h0;
        R_READY   = 1'b0;
        AW_VALID  = 1'b0;
        AW_ADDR   = 32'h0;
        W_VALID   = 1'b0;
        W_DATA    = '0;
        B_READY   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_next = S_AR;
            end
            S_AR: begin
                AR_VALID = 1'b1;
                AR_ADDR  = 32'(w_rd_addr);
                if (AR_READY) w_next = S_R;
            end
            S_R: begin
                R_READY = 1'b1;
                if (R_VALID) w_next = S_WR;
            end
            S_WR: begin
                if (!r_aw_done) begin
                    AW_VALID = 1'b1;
                    AW_ADDR  = 32'(w_wr_addr);
                end
                if (!r_w_done) begin
                    W_VALID = 1'b1;
                    W_DATA  = r_buf;
                end
                if (w_wr_done) w_next = S_B;
            end
            S_B: begin
                B_READY = 1'b1;
                if (B_VALID) w_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = w_shifted[DATA_W-1 -: 8];
                out_last  = w_last_byte && w_last_word;
                if (w_last_byte) w_next = w_last_word ? S_IDLE : S_AR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_buf     <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_byte    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_src <= src_addr;
                        r_dst <= dst_addr;
                        r_len <= len;
                        r_idx <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_R: begin
                    if (R_VALID) begin
                        r_buf <= R_DATA;
                        r_err <= r_err | (|R_RESP);
                    end
                end
                S_WR: begin
                    // AW and W may complete in either order; remember each.
                    if (w_wr_done) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (w_aw_hs) r_aw_done <= 1'b1;
                        if (w_w_hs)  r_w_done  <= 1'b1;
                    end
                end
                S_B: begin
                    if (B_VALID) r_err <= r_err | (|B_RESP);
                end
                S_OUT: begin
                    if (w_last_byte) begin
                        r_byte <= '0;
                        if (!w_last_word) r_idx <= r_idx + 1'b1;
                    end else begin
                        r_byte <= r_byte + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/dram_copy_engine.md
Name: dram_copy_engine

Overview:
- Parametrised DRAM-to-DRAM word mover on the AXI-lite-style DRAM interface already used by the bridge designs.
- On one `in_valid` pulse it copies 1..2^LEN_W consecutive words, ascending from `src_addr` to `dst_addr`.
- Each copied word is also streamed out byte-serially, MSB byte first.
- It generalises the single-word, single-direction transfer to a configurable data width, address width and burst length, and adds error reporting and a last-byte marker.

Parameters:
- DATA_W, 64, DRAM word width in bits; must be a multiple of 8. BYTES = DATA_W/8.
- ADDR_W, 13, DRAM word-address width.
- LEN_W, 4, width of the `len` field; a request carries up to 2^LEN_W words.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  one-cycle request strobe; sampled only in IDLE
- src_addr  input  ADDR_W  first source word address
- dst_addr  input  ADDR_W  first destination word address
- len  input  LEN_W  number of words minus 1
- busy  output  1  high from the cycle after an accepted request until return to IDLE
- out_valid  output  1  byte-stream valid
- out_data  output  8  byte stream; must be 0 whenever out_valid=0
- out_last  output  1  high with the final byte of the final word only
- err  output  1  sticky: set by any R_RESP/B_RESP != 2'b00; cleared on next accepted request
- AR_VALID, AR_READY  output, input  1, 1  read-address handshake
- AR_ADDR  output  32  read address; zero-extended word address
- R_VALID, R_READY  input, output  1, 1  read-data handshake
- R_DATA  input  DATA_W  read data
- R_RESP  input  2  read response
- AW_VALID, AW_READY  output, input  1, 1  write-address handshake
- AW_ADDR  output  32  write address
- W_VALID, W_READY  output, input  1, 1  write-data handshake
- W_DATA  output  DATA_W  write data
- B_VALID, B_READY  input, output  1, 1  write-response handshake
- B_RESP  input  2  write response

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; counters and registers cleared. Reset asserted mid-transfer aborts immediately; no recovery of the partial copy.
- Registered request fields: on in_valid in IDLE, latch src, dst, len; word index i=0; clear err; go to AR. in_valid while busy is ignored.
- AR: AR_VALID=1, AR_ADDR = (src+i) mod 2^ADDR_W, zero-extended. Hold stable until the AR_VALID&AR_READY cycle, then go to R.
- R: R_READY=1. On R_VALID, capture R_DATA into the word buffer and OR err with |R_RESP. Go to WR.
- WR: AW_VALID=1 and W_VALID=1 asserted together. AW_ADDR = (dst+i) mod 2^ADDR_W; W_DATA = buffer.
  - Each VALID deasserts independently after its own handshake.
  - Leave WR when both handshakes have completed, in the same cycle or in different cycles. Go to B.
- B: B_READY=1. On B_VALID, OR err with |B_RESP. Go to OUT.
- OUT: BYTES consecutive cycles with out_valid=1, out_data = buffer[DATA_W-1-8k -: 8] for k=0..BYTES-1, with no gaps inside a word.
  - out_last=1 on k=BYTES-1 when i==len.
  - Then, if i==len, go to IDLE; else i=i+1 and go to AR.
- Idle bus outputs: AR_ADDR, AW_ADDR, W_DATA are 0 whenever their VALID is 0.
- Ordering: word i is written before word i+1 is read. Overlapping ranges therefore behave as a forward sequential copy; with dst=src+1 the source word propagates.
- Wrap-around: address increments wrap modulo 2^ADDR_W; i counts in LEN_W+1 bits.
- Error handling: err does not stop the transfer; the captured data is still written and streamed.
- Minimum latency per word with ready-high slave: 1 AR + 1 R + 1 WR + 1 B = 4 cycles, then BYTES output cycles.
- No combinational path from any input to any output.

Test Plan:
- Reset check: rst_n low 100 ns with clk held -> all outputs 0, including out_data, AR_ADDR, W_DATA.
- Single word: DATA_W=64, src=5, dst=9, len=0, DRAM[5]=64'h0123456789ABCDEF.
  - Required: DRAM[9] equals the same value.
  - out_data sequence 01,23,45,67,89,AB,CD,EF over 8 consecutive out_valid cycles, out_last only on EF.
  - busy low afterwards.
- Burst with wrap: src=8190, dst=100, len=3 -> reads 8190, 8191, 0, 1 in order. DRAM[100..103] hold those words; 32 out_valid cycles total; out_last once.
- Backpressure: slave delays AR_READY 3 cycles, W_READY 5 cycles, AW_READY 1 cycle.
  - Required: VALIDs and addr/data stay stable until their handshake; AW_VALID drops independently of W_VALID.
  - Data is correct; err=0.
- Error and overlap: R_RESP=2'b10 on word 1 of len=2, with src=20, dst=21.
  - Required: err rises after that handshake and stays high; DRAM[21..23] all equal the original DRAM[20].
  - A new in_valid clears err.
- Ignored request and mid-reset: in_valid during a transfer -> no effect. rst_n pulsed during OUT -> out_valid=0 immediately, IDLE, and the next request works normally.
